// File: rtl/serial_loader_pkg.sv
// serial_loader_pkg: shared types and sizes for the serial word loader.
//   ADDR_BITS - address bits carried in each frame
//   NUM_REGS  - registers in the bank (one per address)
//   state_t   - framing FSM states
package serial_loader_pkg;

    localparam int unsigned ADDR_BITS = 3;
    localparam int unsigned NUM_REGS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PAR,
        COMMIT
    } state_t;

endpackage

// File: rtl/decoder_3to8.sv
// decoder_3to8: combinational 3-to-8 one-hot decoder with enable.
//   in  - binary select
//   en  - output enable; out is all zeros when low
//   out - one-hot result
module decoder_3to8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// serial_word_loader: frames a qualified serial bit stream into address + data words and writes
// each word into an eight-entry register bank.
// Frame (MSB first): start '1', 3 address bits, WIDTH data bits, optional even-parity bit.
// Optional feature macro: SERIAL_LOADER_PARITY_EN (adds the parity bit and PAR state).
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset (clears FSM and bank)
//   serial_in  - serial bit, MSB first
//   bit_valid  - qualifies serial_in on a given edge
//   abort      - drops the current frame (cancels a pending write)
//   rd_addr    - read-port register select
//   rd_data    - combinational read of the selected register
//   wr_onehot  - one-hot write enable during COMMIT
//   frame_done - high during COMMIT
//   busy       - high whenever the FSM is not IDLE
//   parity_err - one-cycle pulse after a mismatched parity bit (0 when parity is not built)
module serial_word_loader
    import serial_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic                 bit_valid,
    input  logic                 abort,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic [NUM_REGS-1:0]  wr_onehot,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 parity_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_t                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WIDTH-1:0]       data_q;
    logic [WIDTH-1:0]       bank_q [NUM_REGS];
    logic                   wr_en;
`ifdef SERIAL_LOADER_PARITY_EN
    logic                   parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                bank_q[i] <= '0;
            end
`ifdef SERIAL_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_LOADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (abort) begin
                // Abort outranks everything, including the COMMIT write below.
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // Accepted zeros are line idle.
                        if (bit_valid && serial_in) begin
                            state_q <= ADDR;
                            cnt_q   <= '0;
                        end
                    end
                    ADDR: begin
                        if (bit_valid) begin
                            addr_q <= {addr_q[ADDR_BITS-2:0], serial_in};
                            if (cnt_q == CntW'(ADDR_BITS - 1)) begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (bit_valid) begin
                            data_q <= {data_q[WIDTH-2:0], serial_in};
                            if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SERIAL_LOADER_PARITY_EN
                                state_q <= PAR;
`else
                                state_q <= COMMIT;
`endif
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
`ifdef SERIAL_LOADER_PARITY_EN
                    PAR: begin
                        if (bit_valid) begin
                            cnt_q <= '0;
                            // Even parity: data XOR parity bit must be 0.
                            if (serial_in == ^data_q) begin
                                state_q <= COMMIT;
                            end else begin
                                state_q      <= IDLE;
                                parity_err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    COMMIT: begin
                        state_q         <= IDLE;
                        cnt_q           <= '0;
                        bank_q[addr_q]  <= data_q;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign wr_en      = (state_q == COMMIT) && !abort;
    assign frame_done = (state_q == COMMIT);
    assign busy       = (state_q != IDLE);
    assign rd_data    = bank_q[rd_addr];

`ifdef SERIAL_LOADER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    decoder_3to8 u_decoder (
        .in  (addr_q),
        .en  (wr_en),
        .out (wr_onehot)
    );

endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: directed + randomized frames against a register-bank reference model.
// Honours SERIAL_LOADER_PARITY_EN when defined for the build.
`timescale 1ns/1ps
module tb_serial_word_loader;

    localparam int W = 8;
`ifdef SERIAL_LOADER_PARITY_EN
    localparam int NBITS = 1 + 3 + W + 1;
`else
    localparam int NBITS = 1 + 3 + W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   rd_addr = 3'd0;
    logic [W-1:0] rd_data;
    logic [7:0]   wr_onehot;
    logic         frame_done;
    logic         busy;
    logic         parity_err;

    int checks = 0;
    int passed = 0;
    logic [W-1:0] model [8];

    serial_word_loader #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_onehot  (wr_onehot),
        .frame_done (frame_done),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #0.5;
            chk($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(model[i]));
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        serial_in = 1'($urandom);
    endtask

    // abort_at: frame bit index at which an abort replaces the bit (-1 = none).
    // flip: invert the transmitted parity bit (ignored without parity).
    task automatic send_frame(input logic [2:0] addr, input logic [W-1:0] data, input int gap,
                              input bit lead_zero, input int abort_at, input bit abort_commit,
                              input bit flip);
        logic bits [$];
        bits.push_back(1'b1);
        for (int i = 2; i >= 0; i--) bits.push_back(addr[i]);
        for (int i = W - 1; i >= 0; i--) bits.push_back(data[i]);
`ifdef SERIAL_LOADER_PARITY_EN
        bits.push_back((^data) ^ flip);
`endif
        if (lead_zero) begin
            send_bit(1'b0);
            chk("lead_zero_busy", 32'(busy), 32'd0);
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (i == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 32'd0);
                check_bank("abort");
                return;
            end
            send_bit(bits[i]);
            if (i != bits.size() - 1) repeat (gap) tick();
        end
`ifdef SERIAL_LOADER_PARITY_EN
        if (flip) begin
            chk("perr_pulse", 32'(parity_err), 32'd1);
            chk("perr_busy", 32'(busy), 32'd0);
            chk("perr_wr", 32'(wr_onehot), 32'd0);
            tick();
            chk("perr_clear", 32'(parity_err), 32'd0);
            check_bank("perr");
            return;
        end
        chk("commit_perr", 32'(parity_err), 32'd0);
`endif
        if (abort_commit) begin
            abort = 1'b1;
            #0.5;
            chk("abort_commit_wr", 32'(wr_onehot), 32'd0);
            tick();
            abort = 1'b0;
            chk("abort_commit_busy", 32'(busy), 32'd0);
            check_bank("abort_commit");
            return;
        end
        chk("commit_busy", 32'(busy), 32'd1);
        chk("commit_wr", 32'(wr_onehot), 32'(8'd1 << addr));
        chk("commit_done", 32'(frame_done), 32'd1);
        model[addr] = data;
        tick();
        chk("post_done", 32'(frame_done), 32'd0);
        chk("post_wr", 32'(wr_onehot), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        check_bank("write");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = '0;

        // Reset held for two cycles.
        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr", 32'(wr_onehot), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        check_bank("rst");
        reset = 1'b1;
        tick();

        // Basic write, gapped write with leading idle zero.
        send_frame(3'b101, 8'hA5, 0, 1'b0, -1, 1'b0, 1'b0);
        send_frame(3'b010, 8'h3C, 3, 1'b1, -1, 1'b0, 1'b0);

        // Abort after 4 data bits, then a full frame to reg 0.
        send_frame(3'b000, 8'h77, 0, 1'b0, 8, 1'b0, 1'b0);
        send_frame(3'b000, 8'hFF, 0, 1'b0, -1, 1'b0, 1'b0);
        // Abort during COMMIT.
        send_frame(3'b011, 8'h5A, 0, 1'b0, -1, 1'b1, 1'b0);

        // Back-to-back to reg 7.
        send_frame(3'd7, 8'h11, 0, 1'b0, -1, 1'b0, 1'b0);
        send_frame(3'd7, 8'h22, 0, 1'b0, -1, 1'b0, 1'b0);

`ifdef SERIAL_LOADER_PARITY_EN
        send_frame(3'd4, 8'h01, 0, 1'b0, -1, 1'b0, 1'b1);
        send_frame(3'd4, 8'h01, 0, 1'b0, -1, 1'b0, 1'b0);
`endif

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]   a;
            logic [W-1:0] d;
            int           ab;
            bit           flip;
            a    = 3'($urandom_range(0, 7));
            d    = W'($urandom);
            ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NBITS - 1)) : -1;
            flip = ($urandom_range(0, 4) == 0);
            send_frame(a, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ab,
                       ($urandom_range(0, 7) == 0), flip);
        end

        // Reset mid-frame discards the frame and clears the bank.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        check_bank("midrst");
        tick();
        send_frame(3'd6, 8'hC3, 1, 1'b0, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
